smith_waterman_pe: RTL and testbench
====================================

# smith_waterman_pe

Single processing element of the Smith-Waterman systolic array with affine gap penalties. Each PE holds one short-read base and scores it against a reference stream, one reference base per cycle, producing one DP matrix cell per cycle. PEs chain: a PE's V_out/F_out/T_out/S_out/store_S_out/init_out/cell_score_threshold_out drive the next PE's corresponding inputs.

## Interface
Parameters (positional order as listed):
- SCORE_WIDTH, 10, width of all score signals (two's complement signed)
- MATCH_REWARD, 10, added on base match
- MISMATCH_PEN, -2, added on base mismatch
- GAP_OPEN_PEN, -2, added when opening a gap from V
- GAP_EXTEND_PEN, -1, added when extending a gap

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- stall  in  1  hold all state when high
- V_in  in  SCORE_WIDTH  V of upstream PE, same column
- F_in  in  SCORE_WIDTH  F of upstream PE, same column
- T_in  in  2  reference base
- S_in  in  2  short-read base to store
- store_S_in  in  1  load S_in into PE base register
- init_in  in  1  1 = compute cell; 0 = initialise row state
- init_V  in  SCORE_WIDTH  V loaded on init
- init_E  in  SCORE_WIDTH  E loaded on init
- cell_score_threshold_in  in  SCORE_WIDTH  signed high-score threshold
- V_out, E_out, F_out  out  SCORE_WIDTH  registered V, E, F
- S_out  out  2  stored short-read base
- T_out  out  2  T_in delayed one cycle
- store_S_out, init_out  out  1  inputs delayed one cycle
- cell_score_threshold_out  out  SCORE_WIDTH  threshold delayed one cycle
- high_score_out  out  1  registered cell-score >= threshold flag

## Operation
- Registers: S, V, E, F, Vdiag, T, store_S, init, threshold, high_score.
- Each non-stalled edge:
  - Vdiag <= V_in; T <= T_in; store_S <= store_S_in; init <= init_in; threshold <= cell_score_threshold_in.
  - If store_S_in: S <= S_in.
  - F_new = max(V_in+GAP_OPEN_PEN, F_in+GAP_EXTEND_PEN); F <= F_new (always, incl. init).
- init_in=1 (compute):
  - E_new = max(V+GAP_OPEN_PEN, E+GAP_EXTEND_PEN).
  - s = (T_in==S) ? MATCH_REWARD : MISMATCH_PEN.
  - V_new = max(0, Vdiag+s, E_new, F_new).
  - V <= V_new; E <= E_new; high_score <= (V_new >= cell_score_threshold_in).
- init_in=0 (initialise): V <= init_V; E <= init_E; high_score <= 0.
- Arithmetic: SCORE_WIDTH-bit two's complement, modular (no saturation); all max/compare signed.
- Outputs are direct register values; no combinational input-to-output paths.

## Timing
- Latency 1 cycle for every output.
- stall=1: every register holds, including S and pass-through registers; stall has priority over store_S_in and init_in.
- rst: all registers and outputs 0 immediately, asynchronously.
- store_S_in and init_in both act in the same cycle when asserted together.
- S change takes effect for the score from the next cycle.
- One init cycle (init_in=0) between rows clears horizontal state; without it E/V carry over.

## Test plan
- Params (10,10,-2,-2,-1); load S=A (init_in=0, V_in=F_in=0, init_V=init_E=0), then stream ACAGACTA with init_in=1, threshold 9 -> V_out 10,8,10,8,10,8,7,10; F_out 0x3FF; high_score_out 1,0,1,0,1,0,0,1; store-cycle high_score_out 0 with threshold 0.
- Load S=C with one init cycle, same stream, threshold 8 -> V_out 0,10,8,7,6,10,8,7 (E cleared by init).
- V_in=10, F_in=-4, S=T, threshold 15 -> F_out 8 every cycle; V_out 8,8,8,8,8,8,20,18; high_score_out only on 20,18.
- Pass-through: T_out, init_out, store_S_out, cell_score_threshold_out equal previous-cycle inputs; S_out = S_in one cycle after store.
- Assert stall mid-stream for 3 cycles -> all outputs frozen; sequence resumes identically afterwards.
- Assert rst mid-stream -> all outputs 0 without clock edge.

Source files
------------

// File: rtl/smith_waterman_pe.sv
// -----------------------------------------------------------------------------
// smith_waterman_pe
//
// One processing element of a linear Smith-Waterman systolic array with affine
// gap penalties. The PE holds a single short-read base (S) and scores it
// against a reference stream arriving one base per cycle, producing one DP
// matrix cell per cycle. Vertical state (V, F) and the reference/control
// stream flow to the next PE through registered outputs; horizontal state (E)
// and the diagonal V stay local.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   stall                     hold every register when high
//   V_in, F_in                V and F of the upstream PE, same column
//   T_in                      reference base
//   S_in, store_S_in          short-read base and its load strobe
//   init_in                   1 = compute a cell, 0 = initialise row state
//   init_V, init_E            V/E values loaded on an init cycle
//   cell_score_threshold_in   signed high-score threshold
//   V_out, E_out, F_out       registered cell scores
//   S_out                     stored short-read base
//   T_out, store_S_out,
//   init_out,
//   cell_score_threshold_out  inputs delayed one cycle for the next PE
//   high_score_out            registered (V >= threshold) flag
// -----------------------------------------------------------------------------
module smith_waterman_pe #(
   parameter int SCORE_WIDTH    = 10,
   parameter int MATCH_REWARD   = 10,
   parameter int MISMATCH_PEN   = -2,
   parameter int GAP_OPEN_PEN   = -2,
   parameter int GAP_EXTEND_PEN = -1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          stall,
   input  logic signed [SCORE_WIDTH-1:0] V_in,
   input  logic signed [SCORE_WIDTH-1:0] F_in,
   input  logic        [1:0]             T_in,
   input  logic        [1:0]             S_in,
   input  logic                          store_S_in,
   input  logic                          init_in,
   input  logic signed [SCORE_WIDTH-1:0] init_V,
   input  logic signed [SCORE_WIDTH-1:0] init_E,
   input  logic signed [SCORE_WIDTH-1:0] cell_score_threshold_in,
   output logic signed [SCORE_WIDTH-1:0] V_out,
   output logic signed [SCORE_WIDTH-1:0] E_out,
   output logic signed [SCORE_WIDTH-1:0] F_out,
   output logic        [1:0]             S_out,
   output logic        [1:0]             T_out,
   output logic                          store_S_out,
   output logic                          init_out,
   output logic signed [SCORE_WIDTH-1:0] cell_score_threshold_out,
   output logic                          high_score_out
);

   typedef logic signed [SCORE_WIDTH-1:0] score_t;

   // Penalties truncated to the score width; arithmetic below wraps modulo
   // 2**SCORE_WIDTH, there is deliberately no saturation.
   localparam score_t MatchReward  = score_t'(MATCH_REWARD);
   localparam score_t MismatchPen  = score_t'(MISMATCH_PEN);
   localparam score_t GapOpenPen   = score_t'(GAP_OPEN_PEN);
   localparam score_t GapExtendPen = score_t'(GAP_EXTEND_PEN);

   function automatic score_t smax(input score_t a, input score_t b);
      return (a > b) ? a : b;
   endfunction

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic   [1:0] s_q, s_d;
   score_t       v_q, v_d;
   score_t       e_q, e_d;
   score_t       f_q, f_d;
   score_t       vdiag_q;
   logic   [1:0] t_q;
   logic         store_s_q;
   logic         init_q;
   score_t       thr_q;
   logic         hs_q, hs_d;

   // ---------------------------------------------------------------------------
   // Cell computation
   // ---------------------------------------------------------------------------
   score_t f_open, f_ext;
   score_t e_open, e_ext, e_new;
   score_t sub_score, diag_score;
   score_t v_cell;

   always_comb begin
      // Vertical gap: always tracks the upstream column, even on init cycles.
      f_open = V_in + GapOpenPen;
      f_ext  = F_in + GapExtendPen;
      f_d    = smax(f_open, f_ext);

      // Horizontal gap from this PE's own previous cell.
      e_open = v_q + GapOpenPen;
      e_ext  = e_q + GapExtendPen;
      e_new  = smax(e_open, e_ext);

      // Score uses the base already held in S; a base loaded this cycle only
      // affects the next cell.
      sub_score  = (T_in == s_q) ? MatchReward : MismatchPen;
      diag_score = vdiag_q + sub_score;

      // Local alignment: the cell score never drops below zero.
      v_cell = smax(smax(score_t'(0), diag_score), smax(e_new, f_d));

      if (init_in) begin
         v_d  = v_cell;
         e_d  = e_new;
         hs_d = (v_cell >= cell_score_threshold_in);
      end else begin
         v_d  = init_V;
         e_d  = init_E;
         hs_d = 1'b0;
      end

      s_d = store_S_in ? S_in : s_q;
   end

   // ---------------------------------------------------------------------------
   // Registers: stall freezes everything, including the pass-through stage.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_q       <= '0;
         v_q       <= '0;
         e_q       <= '0;
         f_q       <= '0;
         vdiag_q   <= '0;
         t_q       <= '0;
         store_s_q <= 1'b0;
         init_q    <= 1'b0;
         thr_q     <= '0;
         hs_q      <= 1'b0;
      end else if (!stall) begin
         s_q       <= s_d;
         v_q       <= v_d;
         e_q       <= e_d;
         f_q       <= f_d;
         vdiag_q   <= V_in;
         t_q       <= T_in;
         store_s_q <= store_S_in;
         init_q    <= init_in;
         thr_q     <= cell_score_threshold_in;
         hs_q      <= hs_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs are plain register values.
   // ---------------------------------------------------------------------------
   assign V_out                    = v_q;
   assign E_out                    = e_q;
   assign F_out                    = f_q;
   assign S_out                    = s_q;
   assign T_out                    = t_q;
   assign store_S_out              = store_s_q;
   assign init_out                 = init_q;
   assign cell_score_threshold_out = thr_q;
   assign high_score_out           = hs_q;

endmodule

// File: tb/tb_smith_waterman_pe.sv
// -----------------------------------------------------------------------------
// Testbench for smith_waterman_pe: directed vectors with literal expectations,
// plus an integer reference model compared against every output on every
// falling clock edge.
// -----------------------------------------------------------------------------
module tb_smith_waterman_pe;

   localparam int W     = 10;
   localparam int MR    = 10;
   localparam int MP    = -2;
   localparam int GO    = -2;
   localparam int GE    = -1;
   localparam int BASEA = 0;
   localparam int BASEC = 1;
   localparam int BASEG = 2;
   localparam int BASET = 3;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                stall = 1'b0;
   logic signed [W-1:0] V_in = '0;
   logic signed [W-1:0] F_in = '0;
   logic        [1:0]   T_in = '0;
   logic        [1:0]   S_in = '0;
   logic                store_S_in = 1'b0;
   logic                init_in = 1'b0;
   logic signed [W-1:0] init_V = '0;
   logic signed [W-1:0] init_E = '0;
   logic signed [W-1:0] thr_in = '0;
   logic signed [W-1:0] V_out, E_out, F_out, thr_out;
   logic        [1:0]   S_out, T_out;
   logic                store_S_out, init_out, high_score_out;

   int tests = 0;
   int fails = 0;

   smith_waterman_pe #(
      .SCORE_WIDTH   (W),
      .MATCH_REWARD  (MR),
      .MISMATCH_PEN  (MP),
      .GAP_OPEN_PEN  (GO),
      .GAP_EXTEND_PEN(GE)
   ) dut (
      .clk                     (clk),
      .rst                     (rst),
      .stall                   (stall),
      .V_in                    (V_in),
      .F_in                    (F_in),
      .T_in                    (T_in),
      .S_in                    (S_in),
      .store_S_in              (store_S_in),
      .init_in                 (init_in),
      .init_V                  (init_V),
      .init_E                  (init_E),
      .cell_score_threshold_in (thr_in),
      .V_out                   (V_out),
      .E_out                   (E_out),
      .F_out                   (F_out),
      .S_out                   (S_out),
      .T_out                   (T_out),
      .store_S_out             (store_S_out),
      .init_out                (init_out),
      .cell_score_threshold_out(thr_out),
      .high_score_out          (high_score_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model: plain integers, wrapped to W-bit two's complement.
   // ---------------------------------------------------------------------------
   function automatic int wr(input int x);
      int m;
      m = x & ((1 << W) - 1);
      if (m >= (1 << (W - 1))) m -= (1 << W);
      return m;
   endfunction

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   int m_s, m_v, m_e, m_f, m_vd, m_t, m_st, m_in, m_thr, m_hs;

   always @(posedge clk or posedge rst) begin
      int fn, en, vn, sc;
      if (rst) begin
         m_s = 0; m_v = 0; m_e = 0; m_f = 0; m_vd = 0;
         m_t = 0; m_st = 0; m_in = 0; m_thr = 0; m_hs = 0;
      end else if (!stall) begin
         fn = imax(wr(int'(V_in) + GO), wr(int'(F_in) + GE));
         if (init_in) begin
            en   = imax(wr(m_v + GO), wr(m_e + GE));
            sc   = (int'(T_in) == m_s) ? MR : MP;
            vn   = imax(imax(0, wr(m_vd + sc)), imax(en, fn));
            m_hs = (vn >= int'(thr_in)) ? 1 : 0;
            m_v  = vn;
            m_e  = en;
         end else begin
            m_v  = int'(init_V);
            m_e  = int'(init_E);
            m_hs = 0;
         end
         m_f   = fn;
         m_vd  = int'(V_in);
         m_t   = int'(T_in);
         m_st  = int'(store_S_in);
         m_in  = int'(init_in);
         m_thr = int'(thr_in);
         if (store_S_in) m_s = int'(S_in);
      end
   end

   always @(negedge clk) begin
      chk("model V_out", int'(V_out), m_v);
      chk("model E_out", int'(E_out), m_e);
      chk("model F_out", int'(F_out), m_f);
      chk("model S_out", int'(S_out), m_s);
      chk("model T_out", int'(T_out), m_t);
      chk("model store_S_out", int'(store_S_out), m_st);
      chk("model init_out", int'(init_out), m_in);
      chk("model thr_out", int'(thr_out), m_thr);
      chk("model high_score_out", int'(high_score_out), m_hs);
   end

   // Drive one cycle of inputs, then return just after the following falling
   // edge so the registered results of that cycle are visible.
   task automatic step(input logic stl, input logic st, input int s, input logic ini,
                       input int t, input int vin, input int fin, input int thr,
                       input int iv, input int ie);
      logic [31:0] tmp;
      stall      = stl;
      store_S_in = st;
      tmp = s;   S_in   = tmp[1:0];
      init_in    = ini;
      tmp = t;   T_in   = tmp[1:0];
      tmp = vin; V_in   = tmp[W-1:0];
      tmp = fin; F_in   = tmp[W-1:0];
      tmp = thr; thr_in = tmp[W-1:0];
      tmp = iv;  init_V = tmp[W-1:0];
      tmp = ie;  init_E = tmp[W-1:0];
      @(negedge clk);
      #1;
   endtask

   initial begin
      int seq[8];
      int exp1[8];
      int hs1[8];
      int exp2[8];
      int t3[8];
      int exp3[8];
      int hs3[8];
      int exps[11];
      int k;
      seq  = '{BASEA, BASEC, BASEA, BASEG, BASEA, BASEC, BASET, BASEA};
      exp1 = '{10, 8, 10, 8, 10, 8, 7, 10};
      hs1  = '{1, 0, 1, 0, 1, 0, 0, 1};
      exp2 = '{0, 10, 8, 7, 6, 10, 8, 7};
      t3   = '{BASEA, BASEA, BASEA, BASEA, BASEA, BASEA, BASET, BASEA};
      exp3 = '{8, 8, 8, 8, 8, 8, 20, 18};
      hs3  = '{0, 0, 0, 0, 0, 0, 1, 1};
      exps = '{10, 8, 10, 10, 10, 10, 8, 10, 8, 7, 10};

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      chk("reset V_out", int'(V_out), 0);
      chk("reset high_score_out", int'(high_score_out), 0);
      rst = 1'b0;

      // Row 1: S = A, threshold 9
      step(0, 1, BASEA, 0, BASEA, 0, 0, 0, 0, 0);
      chk("store-cycle high_score_out", int'(high_score_out), 0);
      chk("store-cycle S_out", int'(S_out), BASEA);
      for (int i = 0; i < 8; i++) begin
         step(0, 0, BASEA, 1, seq[i], 0, 0, 9, 0, 0);
         chk($sformatf("row1 V_out[%0d]", i), int'(V_out), exp1[i]);
         chk($sformatf("row1 high_score[%0d]", i), int'(high_score_out), hs1[i]);
         chk($sformatf("row1 F_out[%0d]", i), int'(F_out), -1);
      end

      // Row 2: S = C after one init cycle, threshold 8
      step(0, 1, BASEC, 0, BASEA, 0, 0, 8, 0, 0);
      chk("row2 S_out after store", int'(S_out), BASEC);
      for (int i = 0; i < 8; i++) begin
         step(0, 0, BASEA, 1, seq[i], 0, 0, 8, 0, 0);
         chk($sformatf("row2 V_out[%0d]", i), int'(V_out), exp2[i]);
      end

      // Vertical gap: V_in = 10, F_in = -4, S = T, threshold 15
      step(0, 1, BASET, 0, BASEA, 10, -4, 15, 0, 0);
      chk("row3 init F_out", int'(F_out), 8);
      for (int i = 0; i < 8; i++) begin
         step(0, 0, BASEA, 1, t3[i], 10, -4, 15, 0, 0);
         chk($sformatf("row3 V_out[%0d]", i), int'(V_out), exp3[i]);
         chk($sformatf("row3 F_out[%0d]", i), int'(F_out), 8);
         chk($sformatf("row3 high_score[%0d]", i), int'(high_score_out), hs3[i]);
      end

      // Row 1 again with a 3-cycle stall after the third base; inputs during
      // the stall are deliberately disruptive.
      step(0, 1, BASEA, 0, BASEA, 0, 0, 9, 0, 0);
      k = 0;
      for (int i = 0; i < 3; i++) begin
         step(0, 0, BASEA, 1, seq[i], 0, 0, 9, 0, 0);
         chk($sformatf("stall V_out[%0d]", k), int'(V_out), exps[k]);
         k++;
      end
      for (int i = 0; i < 3; i++) begin
         step(1, 1, BASEG, 0, BASET, 100, 50, -7, 33, 44);
         chk($sformatf("stall V_out[%0d]", k), int'(V_out), exps[k]);
         chk($sformatf("stall T_out[%0d]", k), int'(T_out), BASEA);
         chk($sformatf("stall S_out[%0d]", k), int'(S_out), BASEA);
         k++;
      end
      for (int i = 3; i < 8; i++) begin
         step(0, 0, BASEA, 1, seq[i], 0, 0, 9, 0, 0);
         chk($sformatf("stall V_out[%0d]", k), int'(V_out), exps[k]);
         k++;
      end

      // Pass-through registers
      step(0, 0, BASEA, 1, BASEG, 0, 0, 123, 0, 0);
      chk("pass T_out", int'(T_out), BASEG);
      chk("pass thr_out", int'(thr_out), 123);
      chk("pass init_out", int'(init_out), 1);
      chk("pass store_S_out", int'(store_S_out), 0);
      step(0, 1, BASET, 0, BASEC, 0, 0, -5, 7, 3);
      chk("pass store_S_out set", int'(store_S_out), 1);
      chk("pass init_out clear", int'(init_out), 0);
      chk("pass init_V load", int'(V_out), 7);
      chk("pass init_E load", int'(E_out), 3);
      chk("pass thr_out neg", int'(thr_out), -5);

      // Asynchronous reset mid-stream
      step(0, 0, BASEA, 1, BASET, 0, 0, 9, 0, 0);
      chk("pre-reset V_out", int'(V_out), 10);
      rst = 1'b1;
      #1;
      chk("async reset V_out", int'(V_out), 0);
      chk("async reset E_out", int'(E_out), 0);
      chk("async reset F_out", int'(F_out), 0);
      chk("async reset S_out", int'(S_out), 0);
      chk("async reset T_out", int'(T_out), 0);
      chk("async reset thr_out", int'(thr_out), 0);
      chk("async reset store_S_out", int'(store_S_out), 0);
      chk("async reset init_out", int'(init_out), 0);
      chk("async reset high_score_out", int'(high_score_out), 0);
      @(negedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      #1;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
